czono_loader: RTL

Streaming loader that fills a constrained-zonotope store (dimensions n/ng/nc, centre c, generator matrix G, constraint matrix A, constraint vector b) from a single word-serial input stream. It sits directly upstream of the CZonotope storage. It parses a three-word dimension header, then streams c, G, A and b in a fixed order. Each accepted element becomes one indexed write. It range-checks the header, checks framing, and recovers from malformed packets by draining to end-of-packet.

---
 rtl/czono_loader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/czono_loader.sv
// Word-serial loader for a constrained-zonotope store: parses an n/ng/nc header,
// then emits one indexed write per element of c, G, A and b in that order.
module czono_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NMAX       = 512,
  parameter int unsigned NGMAX      = 512,
  parameter int unsigned NCMAX      = 512,
  localparam int unsigned RMAX  = (NMAX > NCMAX) ? NMAX : NCMAX,
  localparam int unsigned ROW_W = ($clog2(RMAX) > 0) ? $clog2(RMAX) : 1,
  localparam int unsigned COL_W = ($clog2(NGMAX) > 0) ? $clog2(NGMAX) : 1,
  localparam int unsigned NW    = $clog2(NMAX) + 1,
  localparam int unsigned NGW   = $clog2(NGMAX) + 1,
  localparam int unsigned NCW   = $clog2(NCMAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [1:0]            wr_sel,
  output logic [ROW_W-1:0]      wr_row,
  output logic [COL_W-1:0]      wr_col,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NW-1:0]         n,
  output logic [NGW-1:0]        ng,
  output logic [NCW-1:0]        nc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_H2, S_SC, S_SG, S_SA, S_SB, S_DR
  } state_t;

  state_t                  state_q, state_d, next_sec;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [NW-1:0]           hn_q, hn_d;
  logic [NGW-1:0]          hng_q, hng_d;
  logic [NW-1:0]           n_d;
  logic [NGW-1:0]          ng_d;
  logic [NCW-1:0]          nc_d;
  logic                    wr_en_d, busy_d, done_d, err_d;
  logic [1:0]              wr_sel_d, sec_sel;
  logic [ROW_W-1:0]        wr_row_d;
  logic [COL_W-1:0]        wr_col_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic                    xfer, hdr_ok, row_last, col_last, sec_end, in_matrix;
  logic [31:0]             sec_len;

  assign xfer = s_valid && s_ready;

  // Section bookkeeping: length of the current row dimension, end-of-section, successor.
  always_comb begin
    in_matrix = (state_q == S_SG) || (state_q == S_SA);
    sec_len   = ((state_q == S_SC) || (state_q == S_SG)) ? 32'(n) : 32'(nc);
    row_last  = (32'(row_q) == sec_len - 32'd1);
    col_last  = (32'(col_q) == 32'(ng) - 32'd1);
    sec_end   = in_matrix ? (row_last && col_last) : row_last;
    hdr_ok    = (hn_q != '0) && (hn_q <= NW'(NMAX)) && (hng_q <= NGW'(NGMAX)) &&
                (s_data[NCW-1:0] <= NCW'(NCMAX));
    next_sec  = S_H0;
    sec_sel   = 2'd0;
    case (state_q)
      S_SC: begin
        sec_sel  = 2'd0;
        next_sec = (ng != '0) ? S_SG : ((nc != '0) ? S_SB : S_H0);
      end
      S_SG: begin
        sec_sel  = 2'd1;
        next_sec = (nc != '0) ? S_SA : S_H0;
      end
      S_SA: begin
        sec_sel  = 2'd2;
        next_sec = S_SB;
      end
      S_SB: begin
        sec_sel  = 2'd3;
        next_sec = S_H0;
      end
      default: begin
        sec_sel  = 2'd0;
        next_sec = S_H0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    hn_d      = hn_q;
    hng_d     = hng_q;
    n_d       = n;
    ng_d      = ng;
    nc_d      = nc;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel;
    wr_row_d  = wr_row;
    wr_col_d  = wr_col;
    wr_data_d = wr_data;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (xfer) begin
      case (state_q)
        S_H0, S_H1: begin
          if (state_q == S_H0) hn_d = s_data[NW-1:0];
          else                 hng_d = s_data[NGW-1:0];
          busy_d  = 1'b1;
          state_d = (state_q == S_H0) ? S_H1 : S_H2;
          if (s_last) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_H0;
          end
        end
        S_H2: begin
          if (s_last) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_H0;
          end else if (!hdr_ok) begin
            err_d   = 1'b1;
            state_d = S_DR;
          end else begin
            n_d     = hn_q;
            ng_d    = hng_q;
            nc_d    = s_data[NCW-1:0];
            row_d   = '0;
            col_d   = '0;
            state_d = S_SC;
          end
        end
        S_SC, S_SG, S_SA, S_SB: begin
          wr_en_d   = 1'b1;
          wr_sel_d  = sec_sel;
          wr_row_d  = row_q;
          wr_col_d  = col_q;
          wr_data_d = s_data;
          if (sec_end && (next_sec == S_H0)) begin
            // Final element of the packet: s_last must be present here and only here.
            busy_d  = 1'b0;
            state_d = S_H0;
            if (s_last) begin
              done_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              busy_d  = 1'b1;
              state_d = S_DR;
            end
          end else if (s_last) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_H0;
          end else if (sec_end) begin
            row_d   = '0;
            col_d   = '0;
            state_d = next_sec;
          end else if (in_matrix && !col_last) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end
        end
        default: begin
          if (s_last) begin
            busy_d  = 1'b0;
            state_d = S_H0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_H0;
      row_q   <= '0;
      col_q   <= '0;
      hn_q    <= '0;
      hng_q   <= '0;
      n       <= '0;
      ng      <= '0;
      nc      <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= 2'd0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hn_q    <= hn_d;
      hng_q   <= hng_d;
      n       <= n_d;
      ng      <= ng_d;
      nc      <= nc_d;
      wr_en   <= wr_en_d;
      wr_sel  <= wr_sel_d;
      wr_row  <= wr_row_d;
      wr_col  <= wr_col_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      s_ready <= 1'b1;
    end
  end

endmodule
